friscv_axi_rd_arbiter: RTL and testbench

Two-to-one AXI4 read-channel arbiter that shares the single central-memory read port between the instruction-cache memory controller (port s0) and the data-cache memory controller (port s1). AR requests are arbitrated round-robin into a registered output stage, tagged with a per-port ID mask, and limited by per-port outstanding counters. R responses are steered back to the owning port by decoding the returned ID. It sits between the two cache controllers and the top-level memory AXI4 master interface.

---
 rtl/friscv_h.sv | 29 ++
 rtl/friscv_rr_arbiter.sv | 76 +++++++
 rtl/friscv_axi_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_friscv_axi_rd_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_h.sv
// -----------------------------------------------------------------------------
// friscv_h
// Shared constants for the friscv memory subsystem. The cache controllers and
// the read arbiter take their AXI ID masks from here, so a request tagged by a
// controller and the routing decode in the arbiter always agree.
//   ICACHE_ID_MASK / DCACHE_ID_MASK : ID bits that mark instruction / data
//                                     cache traffic on the memory bus
//   S0_IDX / S1_IDX                 : bit positions of the two arbiter ports
// -----------------------------------------------------------------------------
package friscv_h;

    localparam logic [7:0] ICACHE_ID_MASK = 8'h10;
    localparam logic [7:0] DCACHE_ID_MASK = 8'h20;

    localparam int S0_IDX = 0;
    localparam int S1_IDX = 1;

    // Round-robin pointer: names the port that gets the next tie
    typedef enum logic {
        PTR_S0 = 1'b0,
        PTR_S1 = 1'b1
    } rr_ptr_e;

    // One-hot grant vector for a two-port arbiter
    function automatic logic [1:0] one_hot2(input logic sel_s1);
        return sel_s1 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/friscv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// friscv_rr_arbiter
// Two-request grant logic. Grant is combinational and only issued while en is
// high. On a tie the port named by the round-robin pointer wins; the pointer
// then moves to the other port so that both ports alternate under contention.
// With FRISCV_RD_ARB_STRICT_PRIO_EN defined, port 1 always wins a tie and no
// pointer exists (aclk/srst are then unused).
// Ports:
//   aclk, srst : clock, synchronous active-high reset (pointer -> port 0)
//   req[1:0]   : request per port
//   en         : grant allowed this cycle
//   grant[1:0] : one-hot grant (or zero)
// -----------------------------------------------------------------------------
module friscv_rr_arbiter
    import friscv_h::*;
(
    input  logic       aclk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef FRISCV_RD_ARB_STRICT_PRIO_EN

    // Fixed priority: data-cache port (1) beats instruction-cache port (0)
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[S1_IDX]) begin
                grant = 2'b10;
            end else if (req[S0_IDX]) begin
                grant = 2'b01;
            end else begin
                grant = 2'b00;
            end
        end else begin
            grant = 2'b00;
        end
    end

`else

    rr_ptr_e rr_ptr_r;

    // Grant decode: single requester wins, ties go to the pointed port
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = one_hot2(rr_ptr_r == PTR_S1);
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    // Pointer update: after serving a port, point at the other one
    always_ff @(posedge aclk) begin
        if (srst) begin
            rr_ptr_r <= PTR_S0;
        end else if (grant[S0_IDX]) begin
            rr_ptr_r <= PTR_S1;
        end else if (grant[S1_IDX]) begin
            rr_ptr_r <= PTR_S0;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

`endif

endmodule

// File: rtl/friscv_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// friscv_axi_rd_arbiter
// Shares one AXI4 read port between the instruction cache (s0) and the data
// cache (s1). AR requests go through friscv_rr_arbiter into a single registered
// AR stage; each port's ID is OR-ed with its mask so responses can be steered
// back by decoding m_rid. Per-port counters cap the number of reads in flight.
// The R path is purely combinational.
// Configuration macro: FRISCV_RD_ARB_STRICT_PRIO_EN (s1 wins all ties).
// Ports:
//   aclk, srst           : clock, synchronous active-high reset
//   s0_ar* / s1_ar*      : AR slave channels from the cache controllers
//   s0_r*  / s1_r*       : R slave channels back to the cache controllers
//   m_ar*                : registered AR master channel to memory
//   m_r*                 : R master channel from memory
// -----------------------------------------------------------------------------
module friscv_axi_rd_arbiter
    import friscv_h::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W = 8,
    parameter int AXI_DATA_W = 128,
    parameter logic [AXI_ID_W-1:0] ICACHE_ID_MASK = AXI_ID_W'(friscv_h::ICACHE_ID_MASK),
    parameter logic [AXI_ID_W-1:0] DCACHE_ID_MASK = AXI_ID_W'(friscv_h::DCACHE_ID_MASK),
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [AXI_ADDR_W-1:0] s0_araddr,
    input  logic [2:0]            s0_arprot,
    input  logic [AXI_ID_W-1:0]   s0_arid,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [AXI_ID_W-1:0]   s0_rid,
    output logic [1:0]            s0_rresp,
    output logic [AXI_DATA_W-1:0] s0_rdata,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [AXI_ADDR_W-1:0] s1_araddr,
    input  logic [2:0]            s1_arprot,
    input  logic [AXI_ID_W-1:0]   s1_arid,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [AXI_ID_W-1:0]   s1_rid,
    output logic [1:0]            s1_rresp,
    output logic [AXI_DATA_W-1:0] s1_rdata,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic [AXI_ID_W-1:0]   m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [AXI_ID_W-1:0]   m_rid,
    input  logic [1:0]            m_rresp,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic                  m_rlast
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [3:0] cnt0_r;
    logic [3:0] cnt1_r;
    logic       m_arvalid_r;
    logic [AXI_ADDR_W-1:0] m_araddr_r;
    logic [2:0] m_arprot_r;
    logic [AXI_ID_W-1:0] m_arid_r;
    logic [1:0] req_s;
    logic [1:0] grant_s;
    logic       stage_free_s;
    logic       sel_s0_s;
    logic       rdone0_s;
    logic       rdone1_s;

    // Eligibility: valid request and room for one more read in flight
    always_comb begin
        req_s[S0_IDX] = s0_arvalid && (cnt0_r < MAX_CNT);
        req_s[S1_IDX] = s1_arvalid && (cnt1_r < MAX_CNT);
        stage_free_s  = !m_arvalid_r || m_arready;
    end

    // Grant is suppressed during reset so arready stays low while srst is high
    friscv_rr_arbiter u_arb (
        .aclk  (aclk),
        .srst  (srst),
        .req   (req_s),
        .en    (stage_free_s && !srst),
        .grant (grant_s)
    );

    assign s0_arready = grant_s[S0_IDX];
    assign s1_arready = grant_s[S1_IDX];

    // AR output stage: load winner, hold until m_arready, clear when drained
    always_ff @(posedge aclk) begin
        if (srst) begin
            m_arvalid_r <= 1'b0;
            m_araddr_r  <= '0;
            m_arprot_r  <= 3'b000;
            m_arid_r    <= '0;
        end else if (grant_s[S0_IDX]) begin
            m_arvalid_r <= 1'b1;
            m_araddr_r  <= s0_araddr;
            m_arprot_r  <= s0_arprot;
            m_arid_r    <= s0_arid | ICACHE_ID_MASK;
        end else if (grant_s[S1_IDX]) begin
            m_arvalid_r <= 1'b1;
            m_araddr_r  <= s1_araddr;
            m_arprot_r  <= s1_arprot;
            m_arid_r    <= s1_arid | DCACHE_ID_MASK;
        end else if (m_arready) begin
            m_arvalid_r <= 1'b0;
        end else begin
            m_arvalid_r <= m_arvalid_r;
        end
    end

    assign m_arvalid = m_arvalid_r;
    assign m_araddr  = m_araddr_r;
    assign m_arprot  = m_arprot_r;
    assign m_arid    = m_arid_r;

    // R steering: any instruction-cache mask bit in the ID selects s0
    always_comb begin
        sel_s0_s  = (m_rid & ICACHE_ID_MASK) != '0;
        s0_rvalid = m_rvalid && sel_s0_s;
        s1_rvalid = m_rvalid && !sel_s0_s;
        m_rready  = sel_s0_s ? s0_rready : s1_rready;
        rdone0_s  = m_rvalid && m_rready && m_rlast && sel_s0_s;
        rdone1_s  = m_rvalid && m_rready && m_rlast && !sel_s0_s;
    end

    assign s0_rid   = m_rid;
    assign s1_rid   = m_rid;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

    // Next value of an outstanding counter; decrement saturates at zero
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + 4'd1;
            2'b01:   nxt = (cnt != 4'd0) ? (cnt - 4'd1) : 4'd0;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    // Outstanding read counters per port
    always_ff @(posedge aclk) begin
        if (srst) begin
            cnt0_r <= 4'd0;
            cnt1_r <= 4'd0;
        end else begin
            cnt0_r <= cnt_next(cnt0_r, grant_s[S0_IDX], rdone0_s);
            cnt1_r <= cnt_next(cnt1_r, grant_s[S1_IDX], rdone1_s);
        end
    end

endmodule

// File: tb/tb_friscv_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_friscv_axi_rd_arbiter
// Directed bench for the two-port AXI read arbiter with hand-computed
// expectations. Inputs change 1 ns after the rising edge; outputs are checked
// 1 ns later, well before the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_friscv_axi_rd_arbiter;

    logic         aclk;
    logic         srst;
    logic         s0_arvalid, s0_arready, s1_arvalid, s1_arready;
    logic [31:0]  s0_araddr, s1_araddr;
    logic [2:0]   s0_arprot, s1_arprot;
    logic [7:0]   s0_arid, s1_arid;
    logic         s0_rvalid, s0_rready, s1_rvalid, s1_rready;
    logic [7:0]   s0_rid, s1_rid;
    logic [1:0]   s0_rresp, s1_rresp;
    logic [127:0] s0_rdata, s1_rdata;
    logic         m_arvalid, m_arready;
    logic [31:0]  m_araddr;
    logic [2:0]   m_arprot;
    logic [7:0]   m_arid;
    logic         m_rvalid, m_rready, m_rlast;
    logic [7:0]   m_rid;
    logic [1:0]   m_rresp;
    logic [127:0] m_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit strict  = 1'b0;
    logic exp0;

    friscv_axi_rd_arbiter dut (
        .aclk(aclk), .srst(srst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_arprot(s0_arprot), .s0_arid(s0_arid), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_arprot(s1_arprot), .s1_arid(s1_arid), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_rresp(s1_rresp), .s1_rdata(s1_rdata),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rlast(m_rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef FRISCV_RD_ARB_STRICT_PRIO_EN
        strict = 1'b1;
`endif
        srst = 1'b1;
        s0_arvalid = 1'b0; s0_araddr = '0; s0_arprot = '0; s0_arid = '0; s0_rready = 1'b0;
        s1_arvalid = 1'b0; s1_araddr = '0; s1_arprot = '0; s1_arid = '0; s1_rready = 1'b0;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rid = '0; m_rresp = '0; m_rdata = '0; m_rlast = 1'b0;

        // Reset state, with a request present that must not be accepted
        tick();
        tick();
        s0_arvalid = 1'b1;
        #1;
        check("rst_s0_arready", s0_arready, 1'b0);
        check("rst_m_arvalid", m_arvalid, 1'b0);
        check("rst_m_araddr", m_araddr, 32'h0);
        check("rst_m_arid", m_arid, 8'h0);
        tick();
        srst = 1'b0;
        s0_arvalid = 1'b0;
        tick();

        // Single s0 request: accepted at t, visible on master at t+1
        s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arid = 8'h03; s0_arprot = 3'b010;
        #1;
        check("single_s0_arready", s0_arready, 1'b1);
        check("single_s1_arready", s1_arready, 1'b0);
        tick();
        s0_arvalid = 1'b0;
        #1;
        check("single_m_arvalid", m_arvalid, 1'b1);
        check("single_m_araddr", m_araddr, 32'h100);
        check("single_m_arid", m_arid, 8'h13);
        check("single_m_arprot", m_arprot, 3'b010);
        tick();
        check("single_drained", m_arvalid, 1'b0);

        // Response to s0 with fan-out of payload
        m_rvalid = 1'b1; m_rid = 8'h13; m_rlast = 1'b1; m_rresp = 2'b01;
        m_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0; s0_rready = 1'b1;
        #1;
        check("r0_s0_rvalid", s0_rvalid, 1'b1);
        check("r0_s1_rvalid", s1_rvalid, 1'b0);
        check("r0_m_rready", m_rready, 1'b1);
        check("r0_s0_rdata", s0_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
        check("r0_s0_rresp", s0_rresp, 2'b01);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0;
        do_reset();

        // Contention with m_arready=1: alternation (strict: s1 every time)
        s0_arvalid = 1'b1; s0_araddr = 32'hA00; s0_arid = 8'h01;
        s1_arvalid = 1'b1; s1_araddr = 32'hB00; s1_arid = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp0 = strict ? 1'b0 : ((i % 2) == 0);
            check("rr_s0_arready", s0_arready, exp0);
            check("rr_s1_arready", s1_arready, !exp0);
            tick();
            check("rr_m_arid", m_arid, exp0 ? 8'h11 : 8'h22);
        end

        // Master stall for 5 cycles: payload stable, no acceptance
        m_arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_s0_arready", s0_arready, 1'b0);
            check("stall_s1_arready", s1_arready, 1'b0);
            check("stall_m_araddr", m_araddr, 32'hB00);
            check("stall_m_arid", m_arid, 8'h22);
            tick();
        end
        m_arready = 1'b1;
        #1;
        // Round-robin: s1 was last; strict: s1 has hit its limit of 4
        check("unstall_s0_arready", s0_arready, 1'b1);
        check("unstall_s1_arready", s1_arready, 1'b0);
        tick();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        #1;
        check("unstall_m_araddr", m_araddr, 32'hA00);
        do_reset();

        // Counter full on s0: four accepted, fifth stalls, s1 still served
        s0_arvalid = 1'b1; s0_araddr = 32'h200; s0_arid = 8'h05;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_s0_arready", s0_arready, 1'b1);
            tick();
        end
        s1_arvalid = 1'b1; s1_araddr = 32'h300; s1_arid = 8'h06;
        #1;
        check("full_s0_arready", s0_arready, 1'b0);
        check("full_s1_arready", s1_arready, 1'b1);
        tick();
        s1_arvalid = 1'b0;
        #1;
        check("full_m_arid_s1", m_arid, 8'h26);
        check("full_s0_still", s0_arready, 1'b0);
        // Non-last beat must not free a slot
        m_rvalid = 1'b1; m_rid = 8'h15; m_rlast = 1'b0; s0_rready = 1'b1;
        #1;
        check("full_r_s0_rvalid", s0_rvalid, 1'b1);
        check("full_r_s1_rvalid", s1_rvalid, 1'b0);
        tick();
        m_rlast = 1'b1;
        #1;
        check("nonlast_no_free", s0_arready, 1'b0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("last_frees_slot", s0_arready, 1'b1);
        tick();
        s0_arvalid = 1'b0; s0_rready = 1'b0;

        // s1 response with back-pressure; then saturating decrement
        m_rvalid = 1'b1; m_rid = 8'h20; m_rlast = 1'b1; s1_rready = 1'b0; s0_rready = 1'b1;
        m_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        #1;
        check("r1_s1_rvalid", s1_rvalid, 1'b1);
        check("r1_s0_rvalid", s0_rvalid, 1'b0);
        check("r1_m_rready_lo", m_rready, 1'b0);
        check("r1_s1_rid", s1_rid, 8'h20);
        check("r1_s1_rdata", s1_rdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("r1_s0_rdata", s0_rdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        tick();
        s1_rready = 1'b1;
        #1;
        check("r1_m_rready_hi", m_rready, 1'b1);
        tick();
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s1_rready = 1'b0; s0_rready = 1'b0;
        // cnt_1 went 1 -> 0 -> 0: exactly four s1 requests fit now
        s1_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("s1_fill_arready", s1_arready, 1'b1);
            tick();
        end
        #1;
        check("s1_full_arready", s1_arready, 1'b0);
        s1_arvalid = 1'b0;
        do_reset();

        // srst with m_arvalid=1 and cnt_0=3; late R beat still routed
        s0_arvalid = 1'b1; s0_araddr = 32'h400; s0_arid = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        s0_arvalid = 1'b0; m_arready = 1'b0; srst = 1'b1;
        m_rvalid = 1'b1; m_rid = 8'h10; m_rlast = 1'b1; s0_rready = 1'b1;
        #1;
        check("pre_srst_m_arvalid", m_arvalid, 1'b1);
        check("srst_late_s0_rvalid", s0_rvalid, 1'b1);
        tick();
        srst = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0; m_arready = 1'b1;
        #1;
        check("post_srst_m_arvalid", m_arvalid, 1'b0);
        check("post_srst_m_araddr", m_araddr, 32'h0);
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        #1;
        check("post_srst_ptr_s0", s0_arready, !strict);
        check("post_srst_ptr_s1", s1_arready, strict);
        tick();
        s1_arvalid = 1'b0;
        // Counter cleared: s0 completes four in total, then stalls
        for (int i = 0; i < (strict ? 4 : 3); i++) begin
            #1;
            check("post_srst_fill", s0_arready, 1'b1);
            tick();
        end
        #1;
        check("post_srst_full", s0_arready, 1'b0);
        s0_arvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
